fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The parameter RESET_PC SHALL default to 32'd0 and SHALL set the PC load value at reset.
REQ-002 The parameter DEPTH SHALL default to 2 and SHALL set the number of entries in the fetch buffer (legal range 2..8).
REQ-003 The parameter HALT_ON_ZERO SHALL default to 1; when set, fetching the word 32'b0 SHALL halt the sequencer.
REQ-004 The port list SHALL be:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_addr  output  32  address to the combinational instruction memory
- imem_instr  input  32  word returned for imem_addr in the same cycle
- branch_taken  input  1  redirect request
- branch_addr  input  32  redirect target
- freeze  input  1  hazard stall, blocks new fetches
- out_valid  output  1  buffer head valid toward decode
- out_ready  input  1  decode accepts head
- out_instr  output  32  head instruction
- out_pc  output  32  head fetch address + 4
- halted  output  1  high while in HALT

Function
REQ-005 imem_addr SHALL equal the PC register combinationally.
REQ-006 The FSM SHALL have three states: FETCH, FLUSH and HALT.
- Reset: FETCH.
- FETCH -> FLUSH on branch_taken.
- FETCH -> HALT on a zero fetch when HALT_ON_ZERO=1.
- FLUSH -> FETCH after exactly one cycle unless branch_taken is high.
- HALT -> FLUSH on branch_taken; otherwise HALT persists.
REQ-007 A push SHALL occur when all of the following hold: state is FETCH, freeze is low, branch_taken is low, the fetched word is not a halting zero, and (count < DEPTH or a pop occurs in the same cycle).
- A push writes {imem_instr, PC+4} to the tail.
- A push sets PC <= PC+4.
REQ-008 Without a push, PC SHALL hold, except on branch_taken.
REQ-009 A pop SHALL occur when out_valid and out_ready are both high in the same cycle; out_instr/out_pc SHALL then present the next entry from the following cycle.
REQ-010 out_valid SHALL be (count != 0) AND NOT branch_taken, so wrong-path heads are never accepted.
REQ-011 branch_taken SHALL have priority over push, pop, freeze and HALT. In that cycle:
- count <= 0;
- PC <= {branch_addr[31:2], 2'b00};
- state <= FLUSH.
REQ-012 In FLUSH, no push SHALL occur; the first fetch from the target SHALL be pushed in the cycle after FLUSH.
REQ-013 Push and pop in the same cycle SHALL leave count unchanged, including when count == DEPTH.
REQ-014 A halting zero word SHALL NOT be pushed. PC SHALL remain at that address, and entries already buffered SHALL still drain via pops.
REQ-015 PC SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. out_pc SHALL wrap identically.
REQ-016 With HALT_ON_ZERO=0, zero words SHALL be pushed as ordinary instructions.
REQ-017 freeze SHALL NOT block pops or branch_taken.

Reset
REQ-018 Asserting rst_n low at any time, including mid-branch or mid-halt, SHALL immediately force:
- PC = RESET_PC;
- count = 0, with buffer pointers at 0;
- state = FETCH.
REQ-019 During reset, outputs SHALL be: out_valid=0, halted=0, imem_addr=RESET_PC, out_instr=32'b0, out_pc=32'b0.
REQ-020 After rst_n deasserts, the first push SHALL occur on the first rising clk edge.

Structure
REQ-021 The FSM state encoding and the constants WORD_BYTES=4 and NOP_WORD=32'b0 SHALL reside in the shared package fetch_pkg.
REQ-022 The buffer SHALL be a sub-module named fetch_fifo with ports for push, pop, flush, count, and head data.

Verification
REQ-023 Memory holds nonzero words at 0..24 and zero at 28; out_ready=1, no branch. Required response:
- heads pop with out_pc 4, 8, ..., 28, in address order;
- halted rises with PC=28;
- out_valid falls after the last drain.
REQ-024 out_ready=0 from reset. Required response:
- count saturates at 2 (pcs 4, 8) with imem_addr=8;
- when out_ready rises, exactly one push per pop;
- no entry is lost or duplicated.
REQ-025 branch_taken=1 with branch_addr=32'h0000_0013 while count=2. Required response:
- out_valid=0 that cycle;
- PC=32'h10;
- one FLUSH cycle, then the first head has out_pc=32'h14.
REQ-026 freeze=1 for 3 cycles with count=1 and out_ready=1. Required response:
- the head drains;
- PC holds for 3 cycles;
- fetching resumes at the held PC.
REQ-027 RESET_PC=32'hFFFF_FFF8 with nonzero memory everywhere. Required response: pushes carry out_pc FFFF_FFFC, 0000_0000, 0000_0004.
REQ-028 rst_n is pulsed low while in HALT with count=1. Required response:
- immediately out_valid=0, halted=0, PC=RESET_PC;
- fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding and fetch constants for the fetch sequencer.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, FLUSH, HALT} state_t;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'b0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch buffer holding {instr, pc+4} pairs with a combinational head.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [31:0]   push_instr,
    input  logic [31:0]   push_pc,
    output logic [CW-1:0] count,
    output logic [31:0]   head_instr,
    output logic [31:0]   head_pc
);
    localparam int PW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] rd, wr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign {head_instr, head_pc} = mem[rd];

    // Entries are cleared on reset so the head reads as zero while held in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) mem[wr] <= {push_instr, push_pc};
            if (push) wr <= nxt(wr);
            if (pop) rd <= nxt(rd);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing with branch redirect, halt-on-zero and a fetch buffer toward decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int DEPTH = 2,
    parameter bit HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        freeze,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t        state;
    logic [31:0]   pc, next_pc;
    logic [CW-1:0] count;
    logic          zero_hit, pop, push;

    assign imem_addr = pc;
    assign next_pc = pc + WORD_BYTES;
    assign halted = state == HALT;
    assign zero_hit = HALT_ON_ZERO && imem_instr == NOP_WORD;
    assign out_valid = count != '0 && !branch_taken;
    assign pop = out_valid && out_ready;
    assign push = state == FETCH && !freeze && !branch_taken && !zero_hit && (count < FULL || pop);

    // A zero fetch under freeze is not a fetch, so it does not halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            state <= FETCH;
        end else if (branch_taken) begin
            pc <= {branch_addr[31:2], 2'b00};
            state <= FLUSH;
        end else begin
            if (push) pc <= next_pc;
            state <= state == FLUSH ? FETCH : (state == FETCH && zero_hit && !freeze) ? HALT : state;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(branch_taken),
        .push_instr(imem_instr),
        .push_pc(next_pc),
        .count(count),
        .head_instr(out_instr),
        .head_pc(out_pc)
    );
endmodule
